// File: rtl/osc_pkg.sv
// -----------------------------------------------------------------------------
// osc_pkg
// Shared constants and types for the oscilloscope front end. The coupling
// stage and the DC window averager both import this package so that the
// sample width and screen width stay consistent.
//   SAMPLE_W    : ADC sample width in bits
//   SCREEN_W    : samples per screen width (default averaging window)
//   avg_state_t : sequencing states of the DC averager
//   sum_width() : bits needed to hold the sum of n samples of w bits
// -----------------------------------------------------------------------------
package osc_pkg;

  localparam int SAMPLE_W = 8;
  localparam int SCREEN_W = 640;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } avg_state_t;

  // Smallest width that holds n * (2^w - 1) without overflow.
  function automatic int sum_width(input int n, input int w);
    return $clog2(n * ((1 << w) - 1) + 1);
  endfunction

endpackage

// File: rtl/dc_avg_seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Unsigned restoring divider by a constant divisor, one quotient bit per
// clock. The dividend is shifted MSB-first into a partial remainder; each
// step subtracts the divisor when it fits and shifts the resulting quotient
// bit into the vacated LSB of the dividend register, so after DVD_W steps
// that register holds the full quotient.
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   start     in   load dividend and begin dividing (ignored when abort)
//   abort     in   stop any division in progress
//   dividend  in   DVD_W-bit unsigned dividend
//   done      out  high during the cycle whose closing edge computes the
//                  last quotient bit; quotient is valid after that edge
//   quotient  out  low Q_W bits of the quotient
// -----------------------------------------------------------------------------
module seq_div #(
  parameter int DVD_W   = 18,
  parameter int DIVISOR = 640,
  parameter int Q_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DVD_W-1:0] dividend,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  // A remainder is always below DIVISOR, so REM_W bits hold it; one extra
  // bit covers the shifted trial value (at most 2*DIVISOR-1).
  localparam int REM_W  = $clog2(DIVISOR);
  localparam int STEP_W = $clog2(DVD_W);
  localparam logic [REM_W:0]    DIV_WIDE  = DIVISOR[REM_W:0];
  localparam logic [REM_W-1:0]  DIV_LOW   = DIVISOR[REM_W-1:0];
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DVD_W - 1);

  logic [DVD_W-1:0]  r_dvd;
  logic [REM_W-1:0]  r_rem;
  logic [STEP_W-1:0] r_step;
  logic              r_busy;

  logic [REM_W:0]    w_shift;
  logic              w_ge;
  logic [REM_W-1:0]  w_rem_next;
  logic              w_last;

  assign w_shift    = {r_rem, r_dvd[DVD_W-1]};
  assign w_ge       = (w_shift >= DIV_WIDE);
  // When the trial value fits, the difference is below DIVISOR, so the low
  // REM_W bits of the subtraction are exact.
  assign w_rem_next = w_ge ? (w_shift[REM_W-1:0] - DIV_LOW) : w_shift[REM_W-1:0];
  assign w_last     = r_busy && (r_step == LAST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_step <= '0;
      r_busy <= 1'b0;
    end else if (abort) begin
      r_busy <= 1'b0;
    end else if (start) begin
      r_dvd  <= dividend;
      r_rem  <= '0;
      r_step <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_dvd  <= {r_dvd[DVD_W-2:0], w_ge};
      r_rem  <= w_rem_next;
      r_step <= r_step + STEP_W'(1);
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign done     = w_last;
  assign quotient = r_dvd[Q_W-1:0];

endmodule

// File: rtl/dc_avg.sv
// -----------------------------------------------------------------------------
// dc_avg
// Window averager producing the DC offset for the AC/DC coupling stage.
// Accumulates N accepted samples, divides the window sum by N with a
// sequential divider, and holds the floor of the mean until the next
// window completes. Runs continuously; windows follow each other with no gap.
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   asynchronous active-high reset
//   in         in   W-bit unsigned ADC sample
//   in_valid   in   sample accepted on this edge when high
//   clear      in   synchronous window restart; aborts a divide in progress
//   avg        out  current DC level (midscale after reset)
//   avg_valid  out  one-cycle pulse when avg has just been updated
//   busy       out  divider running or result being written
// -----------------------------------------------------------------------------
module dc_avg
  import osc_pkg::*;
#(
  parameter int W = SAMPLE_W,
  parameter int N = SCREEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic         in_valid,
  input  logic         clear,
  output logic [W-1:0] avg,
  output logic         avg_valid,
  output logic         busy
);

  localparam int SUM_W = sum_width(N, W);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N - 1);
  localparam logic [W-1:0]     AVG_RESET = {1'b1, {(W-1){1'b0}}};

  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  avg_state_t       r_state;
  logic [W-1:0]     r_avg;
  logic             r_avg_valid;

  avg_state_t       w_state_next;
  logic             w_accept;
  logic             w_close;
  logic [SUM_W-1:0] w_window_sum;
  logic             w_div_start;
  logic             w_div_abort;
  logic             w_div_done;
  logic             w_write;
  logic [W-1:0]     w_quotient;

  // clear discards any sample on the same edge, including a window-closing one.
  assign w_accept     = in_valid && !clear;
  assign w_close      = w_accept && (r_cnt == LAST_CNT);
  assign w_window_sum = r_sum + SUM_W'(in);

  // ---------------------------------------------------------------------------
  // Accumulator and sample counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_sum <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (w_close) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else begin
        r_sum <= w_window_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_div_start  = 1'b0;
    w_div_abort  = 1'b0;
    w_write      = 1'b0;
    if (clear) begin
      w_state_next = ST_IDLE;
      w_div_abort  = 1'b1;
    end else if (w_close) begin
      // The window is at least 32 samples long, so the previous divide has
      // always finished by the time the next window closes.
      w_state_next = ST_RUN;
      w_div_start  = 1'b1;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_div_done) begin
            w_state_next = ST_WRITE;
          end
        end
        ST_WRITE: begin
          w_write      = 1'b1;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Divider: window sum / N
  // ---------------------------------------------------------------------------
  seq_div #(
    .DVD_W   (SUM_W),
    .DIVISOR (N),
    .Q_W     (W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .abort    (w_div_abort),
    .dividend (w_window_sum),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  // ---------------------------------------------------------------------------
  // Output registers: avg only moves on the avg_valid edge.
  // The mean of W-bit samples always fits in W bits.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avg       <= AVG_RESET;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= w_write;
      if (w_write) begin
        r_avg <= w_quotient;
      end
    end
  end

  assign avg       = r_avg;
  assign avg_valid = r_avg_valid;

endmodule

// File: tb/tb_dc_avg.sv
// -----------------------------------------------------------------------------
// tb_dc_avg
// Self-checking bench for dc_avg. A reference model keeps the accepted
// samples of the current window in a queue, computes floor(sum/N) when the
// window fills, and schedules the expected result LAT edges later. Each
// scenario task drives stimulus and compares the DUT against the model.
// -----------------------------------------------------------------------------
module tb_dc_avg;

  localparam int W   = 8;
  localparam int N   = 640;
  localparam int LAT = 19;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;
  logic         clr;
  logic [W-1:0] avg;
  logic         avg_valid;
  logic         busy;

  always #5 clk = ~clk;

  dc_avg #(.W(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (din_valid),
    .clear     (clr),
    .avg       (avg),
    .avg_valid (avg_valid),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  int win_q[$];
  int pend_val[$];
  int pend_cyc[$];
  int exp_val[$];
  int exp_cyc[$];
  int obs_val[$];
  int obs_cyc[$];
  int exp_avg    = 128;
  int prev_avg   = 128;
  int busy_err   = 0;
  int glitch_err = 0;

  // Drive one clock of stimulus, advance the model, record observations.
  task automatic send(input int v, input bit valid, input bit c);
    int s;
    din       = v[W-1:0];
    din_valid = valid;
    clr       = c;
    @(posedge clk);
    #1;
    cyc++;
    if (c) begin
      win_q.delete();
      pend_val.delete();
      pend_cyc.delete();
    end else begin
      if (pend_cyc.size() > 0 && pend_cyc[0] == cyc) begin
        exp_val.push_back(pend_val[0]);
        exp_cyc.push_back(cyc);
        exp_avg = pend_val[0];
        void'(pend_val.pop_front());
        void'(pend_cyc.pop_front());
      end
      if (valid) begin
        win_q.push_back(v % 256);
        if (win_q.size() == N) begin
          s = 0;
          foreach (win_q[k]) s += win_q[k];
          pend_val.push_back(s / N);
          pend_cyc.push_back(cyc + LAT);
          win_q.delete();
        end
      end
    end
    if (avg_valid === 1'b1) begin
      obs_val.push_back(int'(avg));
      obs_cyc.push_back(cyc);
    end
    if (int'(avg) != prev_avg && avg_valid !== 1'b1) glitch_err++;
    prev_avg = int'(avg);
    if (busy !== (pend_cyc.size() > 0)) busy_err++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(int'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  // Hold reset across two edges and return the model to its reset state.
  task automatic release_reset();
    din_valid = 1'b0;
    clr       = 1'b0;
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst = 1'b0;
    win_q.delete();
    pend_val.delete();
    pend_cyc.delete();
    exp_avg  = 128;
    prev_avg = 128;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    release_reset();
    n_checks++; if (avg !== 8'd128) begin n_fail++; $display("FAIL reset_avg got %0d want 128", avg); end
    n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_avg_valid got %b want 0", avg_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    for (int i = 0; i < N - 1; i++) send(200, 1'b1, 1'b0);
    idle(25);
    n_checks++; if (obs_val.size() !== 0) begin n_fail++; $display("FAIL partial_window_pulses got %0d want 0", obs_val.size()); end
    n_checks++; if (avg !== 8'd128) begin n_fail++; $display("FAIL partial_window_avg got %0d want 128", avg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL partial_window_busy got %b want 0", busy); end
    send(0, 1'b0, 1'b1);
    $display("test_reset: avg=%0d after 639 samples", avg);
  endtask

  task automatic test_constant();
    for (int i = 0; i < N; i++) send(100, 1'b1, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL close_busy got %b want 1", busy); end
    idle(LAT - 1);
    n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid got %b want 0", avg_valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy got %b want 1", busy); end
    n_checks++; if (avg !== 8'd128) begin n_fail++; $display("FAIL early_avg got %0d want 128", avg); end
    idle(1);
    n_checks++; if (avg_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b want 1", avg_valid); end
    n_checks++; if (avg !== 8'd100) begin n_fail++; $display("FAIL const_avg got %0d want 100", avg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL done_busy got %b want 0", busy); end
    idle(1);
    n_checks++; if (avg_valid !== 1'b0) begin n_fail++; $display("FAIL pulse_width got %b want 0", avg_valid); end
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL const_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_constant: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL const_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL const_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_ramp_full();
    for (int i = 0; i < N; i++) send(i % 256, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) send(255, 1'b1, 1'b0);
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL ramp_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    if (obs_val.size() > 0) begin
      n_checks++; if (obs_val[0] !== 114) begin n_fail++; $display("FAIL ramp_avg got %0d want 114", obs_val[0]); end
    end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_ramp_full: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL ramp_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL ramp_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    n_checks++; if (avg !== 8'd255) begin n_fail++; $display("FAIL full_scale_avg got %0d want 255", avg); end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_gaps();
    int nvalid = 0;
    while (nvalid < N) begin
      send(37, 1'b1, 1'b0);
      nvalid++;
      send(int'($urandom_range(0, 255)), 1'b0, 1'b0);
      if (nvalid == N - 1) begin
        idle(LAT + 2);
        n_checks++; if (obs_val.size() !== 0) begin n_fail++; $display("FAIL gap_early_close got %0d want 0", obs_val.size()); end
      end
    end
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL gap_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_gaps: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL gap_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL gap_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    n_checks++; if (avg !== 8'd37) begin n_fail++; $display("FAIL gap_avg got %0d want 37", avg); end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_clear_abort();
    for (int i = 0; i < N; i++) send(50, 1'b1, 1'b0);
    idle(5);
    send(200, 1'b1, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy got %b want 0", busy); end
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== 0) begin n_fail++; $display("FAIL clear_pulses got %0d want 0", obs_val.size()); end
    n_checks++; if (int'(avg) !== exp_avg) begin n_fail++; $display("FAIL clear_avg got %0d want %0d", avg, exp_avg); end
    n_checks++; if (avg !== 8'd37) begin n_fail++; $display("FAIL clear_keep_avg got %0d want 37", avg); end
    // clear coinciding with the window-closing sample must not start a divide
    for (int i = 0; i < N - 1; i++) send(90, 1'b1, 1'b0);
    send(90, 1'b1, 1'b1);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_close_busy got %b want 0", busy); end
    for (int i = 0; i < N; i++) send(64, 1'b1, 1'b0);
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL clear_after_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_clear_abort: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL clear_after_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL clear_after_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    n_checks++; if (avg !== 8'd64) begin n_fail++; $display("FAIL clear_after_avg got %0d want 64", avg); end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 300; i++) send(10, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    n_checks++; if (avg !== 8'd128) begin n_fail++; $display("FAIL async_reset_avg got %0d want 128", avg); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got %b want 0", busy); end
    release_reset();
    for (int i = 0; i < N; i++) send(20, 1'b1, 1'b0);
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL rstmid_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_reset_mid: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL rstmid_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL rstmid_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    n_checks++; if (avg !== 8'd20) begin n_fail++; $display("FAIL rstmid_avg got %0d want 20", avg); end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_random();
    int guard = 0;
    while (exp_val.size() < 3 && guard < 6000) begin
      send(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 1499) == 0));
      guard++;
    end
    idle(LAT + 5);
    n_checks++; if (obs_val.size() !== exp_val.size()) begin n_fail++; $display("FAIL rand_pulses got %0d want %0d", obs_val.size(), exp_val.size()); end
    for (int i = 0; i < exp_val.size() && i < obs_val.size(); i++) begin
      $display("test_random: window avg=%0d at cycle %0d, expected %0d at %0d", obs_val[i], obs_cyc[i], exp_val[i], exp_cyc[i]);
      n_checks++; if (obs_val[i] !== exp_val[i]) begin n_fail++; $display("FAIL rand_value got %0d want %0d", obs_val[i], exp_val[i]); end
      n_checks++; if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL rand_cycle got %0d want %0d", obs_cyc[i], exp_cyc[i]); end
    end
    n_checks++; if (int'(avg) !== exp_avg) begin n_fail++; $display("FAIL rand_avg got %0d want %0d", avg, exp_avg); end
    obs_val.delete(); obs_cyc.delete(); exp_val.delete(); exp_cyc.delete();
  endtask

  task automatic test_hygiene();
    n_checks++; if (busy_err !== 0) begin n_fail++; $display("FAIL busy_tracking got %0d bad cycles want 0", busy_err); end
    n_checks++; if (glitch_err !== 0) begin n_fail++; $display("FAIL avg_stability got %0d changes without avg_valid want 0", glitch_err); end
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    clr       = 1'b0;
    test_reset();
    test_constant();
    test_ramp_full();
    test_gaps();
    test_clear_abort();
    test_reset_mid();
    test_random();
    test_hygiene();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
